usb_tx_ctrl: RTL and testbench

Transmit-side control unit for the USB full-speed device endpoint, the counterpart of the receive control unit. On a start request it sequences one outgoing packet, byte by byte, to the bit serializer/NRZI encoder. A handshake packet is SYNC, PID, EOP. A data packet is SYNC, PID, payload bytes pulled from the shared data buffer, CRC16 (computed internally), EOP. It reports busy/done/error status to the protocol controller.

---
 rtl/usb_tx_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_ctrl.sv
// USB full-speed transmit control: sequences SYNC, PID, optional payload + CRC16, EOP
// to the bit serializer. dbg_state exposes the FSM state (IDLE encodes as 0).
module usb_tx_ctrl #(
    parameter int MAX_PAYLOAD = 64,
    parameter int CNT_BITS    = 7
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_start,
    input  logic [2:0]          tx_packet,
    input  logic                data_toggle,
    input  logic [CNT_BITS-1:0] buffer_occupancy,
    input  logic [7:0]          tx_data,
    input  logic                byte_done,
    input  logic                eop_done,
    output logic [7:0]          tx_byte,
    output logic                load_byte,
    output logic                get_tx_data,
    output logic                send_eop,
    output logic                transmitting,
    output logic                tx_done,
    output logic                tx_error,
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SYNC   = 4'd1,
        S_PID    = 4'd2,
        S_FETCH  = 4'd3,
        S_DATA   = 4'd4,
        S_CRC_LO = 4'd5,
        S_CRC_HI = 4'd6,
        S_EOP    = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          pid_q, pid_nxt;
    logic                is_data_q, is_data_nxt;
    logic [CNT_BITS-1:0] len_q, len_nxt;
    logic [CNT_BITS-1:0] cnt_q, cnt_nxt;
    logic [15:0]         crc_q, crc_nxt;
    logic [7:0]          byte_nxt;
    logic                load_nxt, get_nxt, eop_nxt, err_nxt;
    logic                legal;
    logic [3:0]          req_pid;

    // CRC-16/USB, reflected polynomial, one byte per call
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake: a byte is offered with a one-cycle load_byte pulse on state entry and is
    // considered consumed on the first byte_done seen in that state, entry cycle included.
    always_comb begin
        state_nxt   = state;
        pid_nxt     = pid_q;
        is_data_nxt = is_data_q;
        len_nxt     = len_q;
        cnt_nxt     = cnt_q;
        crc_nxt     = crc_q;
        byte_nxt    = tx_byte;
        load_nxt    = 1'b0;
        get_nxt     = 1'b0;
        eop_nxt     = 1'b0;
        err_nxt     = 1'b0;
        legal       = 1'b1;
        req_pid     = 4'h0;
        case (tx_packet)
            3'b011:  req_pid = data_toggle ? 4'hB : 4'h3;
            3'b100:  req_pid = 4'h2;
            3'b101:  req_pid = 4'hA;
            3'b110:  req_pid = 4'hE;
            default: legal   = 1'b0;
        endcase

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    if (!legal || (tx_packet == 3'b011 &&
                        buffer_occupancy > CNT_BITS'(MAX_PAYLOAD))) begin
                        err_nxt = 1'b1;
                    end else begin
                        pid_nxt     = req_pid;
                        is_data_nxt = (tx_packet == 3'b011);
                        len_nxt     = buffer_occupancy;
                        cnt_nxt     = '0;
                        crc_nxt     = 16'hFFFF;
                        byte_nxt    = 8'h80;
                        load_nxt    = 1'b1;
                        state_nxt   = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                if (byte_done) begin
                    byte_nxt  = {~pid_q, pid_q};
                    load_nxt  = 1'b1;
                    state_nxt = S_PID;
                end
            end
            S_PID: begin
                if (byte_done) begin
                    if (!is_data_q) begin
                        eop_nxt   = 1'b1;
                        state_nxt = S_EOP;
                    end else if (len_q != '0) begin
                        get_nxt   = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        byte_nxt  = ~crc_q[7:0];
                        load_nxt  = 1'b1;
                        state_nxt = S_CRC_LO;
                    end
                end
            end
            S_FETCH: begin
                // get_tx_data is high only on entry; read data is valid the cycle after
                if (!get_tx_data) begin
                    byte_nxt  = tx_data;
                    crc_nxt   = crc16_byte(crc_q, tx_data);
                    load_nxt  = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    cnt_nxt = cnt_q + CNT_BITS'(1);
                    if (cnt_q + CNT_BITS'(1) == len_q) begin
                        byte_nxt  = ~crc_q[7:0];
                        load_nxt  = 1'b1;
                        state_nxt = S_CRC_LO;
                    end else begin
                        get_nxt   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_CRC_LO: begin
                if (byte_done) begin
                    byte_nxt  = ~crc_q[15:8];
                    load_nxt  = 1'b1;
                    state_nxt = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (byte_done) begin
                    eop_nxt   = 1'b1;
                    state_nxt = S_EOP;
                end
            end
            S_EOP: begin
                if (eop_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pid_q       <= 4'h0;
            is_data_q   <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            crc_q       <= 16'hFFFF;
            tx_byte     <= 8'h00;
            load_byte   <= 1'b0;
            get_tx_data <= 1'b0;
            send_eop    <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            pid_q       <= pid_nxt;
            is_data_q   <= is_data_nxt;
            len_q       <= len_nxt;
            cnt_q       <= cnt_nxt;
            crc_q       <= crc_nxt;
            tx_byte     <= byte_nxt;
            load_byte   <= load_nxt;
            get_tx_data <= get_nxt;
            send_eop    <= eop_nxt;
            tx_error    <= err_nxt;
        end
    end

    assign transmitting = (state != S_IDLE) && (state != S_DONE);
    assign tx_done      = (state == S_DONE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Bench for usb_tx_ctrl: randomized serializer/buffer responder plus a packet-level
// reference model (byte list and CRC-16/USB computed from payload).
module tb_usb_tx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic       data_toggle;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_data;
    logic       byte_done;
    logic       eop_done;
    logic [7:0] tx_byte;
    logic       load_byte;
    logic       get_tx_data;
    logic       send_eop;
    logic       transmitting;
    logic       tx_done;
    logic       tx_error;
    logic [3:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] pay_q[$];

    int  get_cnt = 0, eop_cnt = 0, err_cnt = 0;
    int  get_cyc = 0, eop_cyc = 0;
    bit  get_pend = 0, bd_pend = 0, eop_pend = 0, spur_en = 0;
    int  bd_wait = 0, eop_wait = 0;

    usb_tx_ctrl #(.MAX_PAYLOAD(64), .CNT_BITS(7)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
        .data_toggle(data_toggle), .buffer_occupancy(buffer_occupancy),
        .tx_data(tx_data), .byte_done(byte_done), .eop_done(eop_done),
        .tx_byte(tx_byte), .load_byte(load_byte), .get_tx_data(get_tx_data),
        .send_eop(send_eop), .transmitting(transmitting), .tx_done(tx_done),
        .tx_error(tx_error), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // serializer + data buffer responder
    initial begin
        byte_done = 1'b0;
        eop_done  = 1'b0;
        tx_data   = 8'h00;
        forever begin
            @(negedge clk);
            byte_done = 1'b0;
            eop_done  = 1'b0;
            if (!n_rst) begin
                bd_pend = 0; eop_pend = 0; get_pend = 0;
            end else begin
                if (get_tx_data) begin
                    get_cnt++;
                    get_cyc  = cyc;
                    get_pend = 1;
                    tx_data  = (pay_q.size() > 0) ? pay_q.pop_front() : 8'h00;
                end
                if (load_byte) begin
                    obs_q.push_back(tx_byte);
                    if (get_pend) begin
                        check_eq("fetch_latency", cyc - get_cyc, 2);
                        get_pend = 0;
                    end
                    bd_pend = 1;
                    bd_wait = $urandom_range(0, 3);
                end
                if (send_eop) begin
                    eop_cnt++;
                    eop_pend = 1;
                    eop_wait = $urandom_range(0, 3);
                end
                if (tx_error) err_cnt++;
                if (bd_pend) begin
                    if (bd_wait == 0) begin
                        byte_done = 1'b1;
                        bd_pend   = 0;
                    end else begin
                        bd_wait--;
                    end
                end else if (spur_en && get_tx_data) begin
                    byte_done = 1'b1;
                end
                if (eop_pend) begin
                    if (eop_wait == 0) begin
                        eop_done = 1'b1;
                        eop_pend = 0;
                        eop_cyc  = cyc;
                    end else begin
                        eop_wait--;
                    end
                end else if (spur_en && transmitting && $urandom_range(0, 2) == 0) begin
                    eop_done = 1'b1;
                end
            end
        end
    end

    // reference model: the byte sequence a packet should put on the wire
    task automatic build_expected(input logic [2:0] ptype, input bit tog, input int len,
                                  input bit seq);
        logic [15:0] crc;
        logic [7:0]  b;
        exp_q.delete();
        pay_q.delete();
        obs_q.delete();
        exp_q.push_back(8'h80);
        case (ptype)
            3'b011:  exp_q.push_back(tog ? 8'h4B : 8'hC3);
            3'b100:  exp_q.push_back(8'hD2);
            3'b101:  exp_q.push_back(8'h5A);
            default: exp_q.push_back(8'h1E);
        endcase
        if (ptype == 3'b011) begin
            crc = 16'hFFFF;
            for (int i = 0; i < len; i++) begin
                b = seq ? 8'(8'h31 + i) : 8'($urandom_range(0, 255));
                pay_q.push_back(b);
                exp_q.push_back(b);
                crc = crc ^ {8'h00, b};
                for (int k = 0; k < 8; k++) begin
                    crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
                end
            end
            exp_q.push_back(~crc[7:0]);
            exp_q.push_back(~crc[15:8]);
        end
    endtask

    task automatic start_req(input logic [2:0] ptype, input bit tog, input int occ);
        @(negedge clk);
        tx_start         = 1'b1;
        tx_packet        = ptype;
        data_toggle      = tog;
        buffer_occupancy = 7'(occ);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic send_packet(input logic [2:0] ptype, input bit tog, input int len,
                               input int occ, input bit seq, input bit poke);
        int  get0, eop0, err0;
        bit  done, poked;
        build_expected(ptype, tog, len, seq);
        get0 = get_cnt; eop0 = eop_cnt; err0 = err_cnt;
        done = 0; poked = 0;
        start_req(ptype, tog, occ);
        check_eq("busy_after_start", transmitting, 1);
        for (int n = 0; n < 3000 && !done; n++) begin
            if (tx_done) begin
                done = 1;
            end else begin
                tx_start = poke && !poked && (get_cnt != get0);
                if (tx_start) begin
                    poked     = 1;
                    tx_packet = 3'b100;
                end
                @(negedge clk);
                tx_start = 1'b0;
            end
        end
        check_eq("done_seen", done, 1);
        if (done) begin
            check_eq("done_latency", cyc - eop_cyc, 1);
            check_eq("busy_at_done", transmitting, 0);
            @(negedge clk);
            check_eq("done_single", tx_done, 0);
            check_eq("idle_after", dbg_state, 0);
        end
        check_eq("byte_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("byte%0d", i), obs_q[i], exp_q[i]);
        end
        check_eq("reads", get_cnt - get0, (ptype == 3'b011) ? len : 0);
        check_eq("eops", eop_cnt - eop0, 1);
        check_eq("no_error", err_cnt - err0, 0);
    endtask

    task automatic err_case(input logic [2:0] ptype, input int occ);
        start_req(ptype, 1'b0, occ);
        check_eq("err_pulse", tx_error, 1);
        check_eq("err_no_load", load_byte, 0);
        check_eq("err_not_busy", transmitting, 0);
        @(negedge clk);
        check_eq("err_single", tx_error, 0);
        check_eq("err_idle", dbg_state, 0);
        check_eq("err_no_load2", load_byte, 0);
    endtask

    task automatic reset_mid_data();
        int get0, g;
        build_expected(3'b011, 1'b0, 10, 1'b0);
        get0 = get_cnt;
        start_req(3'b011, 1'b0, 10);
        for (int n = 0; n < 500 && (get_cnt - get0) < 3; n++) @(negedge clk);
        check_eq("reset_reached_data", (get_cnt - get0) >= 3, 1);
        n_rst = 1'b0;
        #1;
        check_eq("reset_outputs", {tx_byte, load_byte, get_tx_data, send_eop, transmitting,
                                   tx_done, tx_error}, 0);
        check_eq("reset_state", dbg_state, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        g = get_cnt;
        repeat (6) @(negedge clk);
        check_eq("reset_no_reads", get_cnt - g, 0);
        check_eq("reset_not_busy", transmitting, 0);
        check_eq("reset_no_done", tx_done, 0);
    endtask

    initial begin
        logic [2:0] types[4];
        int t, len;
        types[0] = 3'b011; types[1] = 3'b100; types[2] = 3'b101; types[3] = 3'b110;
        n_rst = 1'b0;
        tx_start = 1'b0; tx_packet = 3'b000; data_toggle = 1'b0; buffer_occupancy = 7'd0;
        repeat (3) @(negedge clk);
        check_eq("por_outputs", {tx_byte, load_byte, get_tx_data, send_eop, transmitting,
                                 tx_done, tx_error}, 0);
        check_eq("por_state", dbg_state, 0);
        n_rst = 1'b1;
        @(negedge clk);

        send_packet(3'b100, 1'b0, 0, 0, 1'b0, 1'b0);
        send_packet(3'b011, 1'b1, 0, 0, 1'b0, 1'b0);
        send_packet(3'b011, 1'b0, 9, 9, 1'b1, 1'b0);
        if (obs_q.size() == 13) begin
            check_eq("crc_lo_123456789", obs_q[11], 8'hC8);
            check_eq("crc_hi_123456789", obs_q[12], 8'hB4);
        end else begin
            check_eq("crc_vector_len", obs_q.size(), 13);
        end
        send_packet(3'b011, 1'b1, 64, 64, 1'b0, 1'b0);

        err_case(3'b001, 0);
        err_case(3'b111, 0);
        err_case(3'b011, 65);
        err_case(3'b011, 127);

        spur_en = 1;
        send_packet(3'b011, 1'b0, 5, 5, 1'b0, 1'b1);
        send_packet(3'b101, 1'b0, 0, 100, 1'b0, 1'b0);

        reset_mid_data();
        send_packet(3'b100, 1'b0, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            t   = $urandom_range(0, 3);
            len = $urandom_range(0, 20);
            if (types[t] == 3'b011) begin
                send_packet(types[t], 1'($urandom_range(0, 1)), len, len, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                send_packet(types[t], 1'($urandom_range(0, 1)), 0, $urandom_range(0, 127), 1'b0, 1'b0);
            end
        end
        spur_en = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
